// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Request/response bundle between the EX stage and the divide sequencer.
//   start/flush   : EX-stage request level and pipeline kill
//   funct3        : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1/rs2       : dividend / divisor
//   busy          : stall request back to PC/IF/ID/EX
//   done          : result valid this cycle
//   result        : registered quotient or remainder
// master = EX stage side, slave = divide sequencer side.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   dbus : div_sequencer_if.slave (start/flush/funct3/rs1/rs2 in,
//          busy/done/result out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; special cases resolved here
// CALC   | XLEN restoring iterations, counter counts down to 0
// DONE   | result valid for one cycle, start ignored
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  dbus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            op_signed, op_rem;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_abs, rs2_abs;
  logic            div_zero, ovf;

  logic [XLEN:0]   rem_sh, trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_step, quo_step, sel;

  assign op_signed = ~dbus.funct3[0];
  assign op_rem    = dbus.funct3[1];
  assign rs1_neg   = op_signed & dbus.rs1[XLEN-1];
  assign rs2_neg   = op_signed & dbus.rs2[XLEN-1];
  assign rs1_abs   = rs1_neg ? -dbus.rs1 : dbus.rs1;
  assign rs2_abs   = rs2_neg ? -dbus.rs2 : dbus.rs2;
  assign div_zero  = (dbus.rs2 == '0);
  assign ovf       = op_signed && (dbus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (dbus.rs2 == '1);

  // Partial remainder is always below the divisor, so after the shift it
  // fits in XLEN+1 bits and the trial difference's MSB is its sign.
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign trial_ok = ~trial[XLEN];
  assign rem_step = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], trial_ok};
  assign sel      = is_rem_q ? rem_step : quo_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    if (dbus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dbus.start) begin
            is_rem_d = op_rem;
            neg_q_d  = rs1_neg ^ rs2_neg;
            neg_r_d  = rs1_neg;
            dvs_d    = rs2_abs;
            if (div_zero) begin
              // Divide-by-zero quotient is all-ones regardless of sign.
              result_d = op_rem ? dbus.rs1 : '1;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_d  = S_DONE;
            end else begin
              cnt_d   = CW'(XLEN-1);
              rem_d   = '0;
              quo_d   = rs1_abs;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == '0) begin
            result_d = (is_rem_q ? neg_r_q : neg_q_q) ? -sel : sel;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  // busy is gated by rst so the stall drops the instant reset asserts,
  // even while start is still high.
  assign dbus.busy   = ~rst & (((state_q == S_IDLE) & dbus.start & ~dbus.flush) |
                               (state_q == S_CALC));
  assign dbus.done   = (state_q == S_DONE);
  assign dbus.result = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Directed vectors for div_sequencer with hand-computed results, latency,
// busy width, flush and asynchronous reset behaviour.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(32)) bus();

  div_sequencer #(.XLEN(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .dbus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge (cycle 0), drop start after cycle 0,
  // observe 1ns after each negedge.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int done_cyc = -1;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    #1;
    for (int cyc = 0; cyc <= exp_lat + 4; cyc++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res      = bus.result;
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
      #1;
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, " done_width"}, 32'(done_cnt), 32'd1);
    check({tag, " result"}, res, exp_res);
    check({tag, " result_hold"}, bus.result, exp_res);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcnt;
    int dcyc [2];
    logic [31:0] dres [2];

    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b100;
    bus.rs1    = '0;
    bus.rs2    = '0;
    #2;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    #20;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op("div_20_m3", 3'b100, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);

    // flush at cycle 10 of a DIV: no done, result keeps 0xFFFFFFFA
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush busy_after", {31'd0, bus.busy}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      if (bus.done) dcnt++;
      @(negedge clk);
      #1;
    end
    check("flush no_done", 32'(dcnt), 32'd0);
    check("flush result_kept", bus.result, 32'hFFFF_FFFA);

    run_op("rem_20_m3",  3'b110, 32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 33);
    run_op("rem_m20_3",  3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);

    // async reset mid-CALC with start high: outputs clear before the edge
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.rs1    = 32'd100;
    bus.rs2    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst       = 1'b1;
    bus.start = 1'b1;
    #1;
    check("async_rst busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst done", {31'd0, bus.done}, 32'd0);
    check("async_rst result", bus.result, 32'd0);
    bus.start = 1'b0;
    #1;
    rst = 1'b0;

    run_op("div_m100_7_after_rst", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("divu_max_10", 3'b101, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33);
    run_op("remu_max_10", 3'b111, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 33);
    run_op("divu_1_max",  3'b101, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("divu_7_0",    3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_m7_0",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_7_0",     3'b110, 32'd7,         32'd0,         32'h0000_0007, 1);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_ovf_ops",3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

    // start held across DONE: 100/7 then 50/5 sampled in cycle 34
    dcnt = 0;
    dcyc[0] = -1; dcyc[1] = -1;
    dres[0] = '0; dres[1] = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.rs1    = 32'd100;
    bus.rs2    = 32'd7;
    #1;
    for (int cyc = 0; cyc <= 70; cyc++) begin
      if (bus.done) begin
        if (dcnt < 2) begin
          dcyc[dcnt] = cyc;
          dres[dcnt] = bus.result;
        end
        dcnt++;
      end
      if (cyc == 33) check("b2b busy_in_done", {31'd0, bus.busy}, 32'd0);
      if (cyc == 34) check("b2b busy_restart", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      if (cyc == 0) begin
        bus.rs1 = 32'd50;
        bus.rs2 = 32'd5;
      end
      #1;
    end
    check("b2b done_count", 32'(dcnt), 32'd2);
    check("b2b first_cycle", 32'(dcyc[0]), 32'd33);
    check("b2b first_result", dres[0], 32'd14);
    check("b2b second_cycle", 32'(dcyc[1]), 32'd67);
    check("b2b second_result", dres[1], 32'd10);
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("b2b flushed_idle", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative sequencer for the M-extension divide/remainder instructions (DIV, DIVU, REM, REMU) in the EX stage of the pipelined femtoRV32 core. It accepts a request from the EX-stage instruction and stalls the pipeline with `busy` while a restoring divider runs one quotient bit per cycle. It then presents a registered 32-bit result for one cycle with `done`. Divide-by-zero and signed overflow complete early with RISC-V-mandated results.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: level request; high while a divide-class instruction is in EX.
- `flush` input 1: synchronous kill of the in-flight operation (branch/jump flush of EX).
- `funct3` input 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled with `start`.
- `rs1` input XLEN: dividend; sampled with `start`.
- `rs2` input XLEN: divisor; sampled with `start`.
- `busy` output 1: pipeline stall request (PC/IF/ID/EX hold).
- `done` output 1: result valid this cycle; EX may advance.
- `result` output XLEN: quotient or remainder; registered.

## Operation
- States: IDLE, CALC, DONE. State encoding is free.
- IDLE, `start`=1, `flush`=0:
  - Latch the operation: signed flag = ~funct3[0], rem flag = funct3[1].
  - Latch |rs1| and |rs2| (magnitude only for signed ops).
  - Latch sign_q = rs1[XLEN-1]^rs2[XLEN-1] and sign_r = rs1[XLEN-1] (signed ops; 0 for unsigned).
  - rs2==0 → DONE. result = rem ? rs1 : all-ones.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF → DONE. result = rem ? 0 : 0x80000000.
  - Otherwise → CALC, with counter = XLEN-1, partial remainder = 0, and quotient register = |rs1|.
- CALC, each cycle (restoring step):
  - Shift {rem, quo} left 1.
  - Trial = rem_shifted − divisor (XLEN+1 bits).
  - Trial non-negative → rem = trial[XLEN-1:0] and quo LSB = 1; otherwise keep the shifted rem and set quo LSB = 0.
  - When counter==0, go to DONE and load `result`: selected value (quo or rem), two's-complement negated when sign_q (quotient) or sign_r (remainder) applies.
  - Otherwise decrement the counter.
- DONE:
  - `done`=1 and `result` stable; `start` is ignored (it is the finishing instruction still in EX).
  - → IDLE unconditionally.
- `flush`=1 in any state → IDLE next edge. No `done`, `result` unchanged. `flush` has priority over `start`.
- `busy` is combinational: (IDLE & `start` & ~`flush`) | CALC. It is 0 in DONE.
- Reset (async, any state): state IDLE, `result`=0, counter=0, internal registers 0. `done`=0; `busy` is forced 0 while `rst` is high.

## Timing
- Start is sampled in cycle 0 (IDLE, `start`=1).
- Normal op:
  - `busy`=1 in cycles 0..32, i.e. cycle 0 plus 32 CALC cycles.
  - `done`=1 in cycle 33.
  - Total latency is XLEN+1 cycles from the sampling edge to `done`.
- Special cases (div-by-zero, overflow): `busy`=1 in cycle 0 only, `done`=1 in cycle 1.
- `done` is exactly one cycle wide.
- After DONE the unit is in IDLE for one cycle, so back-to-back divides restart in cycle 34 (the next instruction's first EX cycle).
- `result` holds its value until the next DONE entry or reset.
- `flush` in cycle k of CALC: IDLE at cycle k+1. `busy`=0 at k+1 unless `start` is asserted there.
- Async reset mid-CALC: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- DIV rs1=20, rs2=0xFFFFFFFD (−3) → `busy` 1 in cycles 0–32, `done` pulse in cycle 33, `result`=0xFFFFFFFA (−6); REM with the same operands → 0x00000002.
- REM rs1=0xFFFFFFEC (−20), rs2=3 → 0xFFFFFFFE (−2).
  - DIVU 0xFFFFFFFF/10 → 0x19999999.
  - REMU 0xFFFFFFFF/10 → 5.
  - DIVU 1/0xFFFFFFFF → 0.
- Divide-by-zero: DIVU 7/0 → 0xFFFFFFFF; DIV −7/0 → 0xFFFFFFFF; REM 7%0 → 7. Each has `done` in cycle 1 and `busy` only in cycle 0.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Both finish with `done` in cycle 1; DIVU with the same operands takes the full 33 cycles and gives 0x00000000.
- `flush` asserted at cycle 10 of a DIV → no `done` and `result` unchanged. Separately, `rst` pulsed mid-CALC asynchronously → `busy`, `done` and `result` become 0 before the next edge. A subsequent op then completes correctly.
- `start` held high across DONE with operands 100/7 and then 50/5 → DONE does not retrigger. The second op is sampled in cycle 34, `done` occurs in cycle 67, and the results are 14 then 10.
